// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch sequencer: owns the PC, issues requests to a
// variable-latency instruction memory over a req/ready handshake and writes
// the IF/ID pipeline register. Handles ID-stage stalls (hold buffer) and
// EX/MEM branch redirects (flush; deferred while a request is outstanding).
//
// Optional feature (macro FETCH_TIMEOUT_EN): adds parameter TIMEOUT_CYC and a
// sticky fetch_err output; a request that waits TIMEOUT_CYC cycles is dropped
// for one cycle and reissued.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   ex_mem_pcsrc  redirect taken (EX/MEM)
//   ex_mem_npc    redirect target
//   id_stall      hazard unit holds IF/ID
//   imem_req      fetch request (registered)
//   imem_addr     fetch address, stable until accepted (registered)
//   imem_ready    memory completes the transaction this cycle
//   imem_rdata    instruction word
//   if_id_instr   IF/ID instruction
//   if_id_npc     IF/ID next PC (fetch address + PC_INC)
//   if_id_valid   IF/ID holds a real instruction
//   fetch_err     sticky timeout flag (FETCH_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_INC    = 32'h0000_0001,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_pcsrc,
   input  logic [31:0] ex_mem_npc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_npc,
   output logic        if_id_valid
`ifdef FETCH_TIMEOUT_EN
   ,
   output logic        fetch_err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state, state_d;

   logic [31:0] pc, pc_d;
   logic [31:0] req_addr, req_addr_d;
   logic [31:0] redir_pc, redir_pc_d;
   logic        redir_pend, redir_pend_d;
   logic [31:0] hold_instr, hold_instr_d;
   logic [31:0] hold_npc, hold_npc_d;
   logic [31:0] instr_d, npc_d;
   logic        valid_d;
   logic        req_d;

   logic        done;
   logic        waiting;
   logic        timeout;
   logic [31:0] seq_npc;

   assign imem_addr = req_addr;
   assign done      = imem_req & imem_ready;
   assign waiting   = imem_req & ~imem_ready;
   assign seq_npc   = req_addr + PC_INC;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
   logic             fetch_err_d;

   // Timeout fires on the TIMEOUT_CYC-th consecutive unanswered request cycle
   assign timeout     = waiting & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign tmo_cnt_d   = (waiting & ~timeout) ? tmo_cnt + TMO_W'(1) : '0;
   assign fetch_err_d = fetch_err | timeout;

   // Wait counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt   <= '0;
         fetch_err <= 1'b0;
      end else begin
         tmo_cnt   <= tmo_cnt_d;
         fetch_err <= fetch_err_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state and next-register-value logic
   always_comb begin
      state_d      = state;
      pc_d         = pc;
      req_addr_d   = req_addr;
      redir_pc_d   = redir_pc;
      redir_pend_d = redir_pend;
      hold_instr_d = hold_instr;
      hold_npc_d   = hold_npc;
      instr_d      = if_id_instr;
      npc_d        = if_id_npc;
      valid_d      = if_id_valid;

      // Without a delivery IF/ID takes a bubble, unless ID is stalled
      if (!id_stall) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end

      if (ex_mem_pcsrc) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         if (!imem_req || done) begin
            pc_d         = ex_mem_npc;
            redir_pend_d = 1'b0;
            state_d      = S_REQ;
         end else if (timeout) begin
            pc_d         = ex_mem_npc;
            redir_pend_d = 1'b0;
            state_d      = S_IDLE;
         end else begin
            // Address must stay stable: remember the target until completion
            redir_pc_d   = ex_mem_npc;
            redir_pend_d = 1'b1;
            state_d      = S_WAIT;
         end
      end else if (timeout) begin
         pc_d         = redir_pend ? redir_pc : req_addr;
         redir_pend_d = 1'b0;
         state_d      = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               state_d = S_REQ;
            end
            S_REQ, S_WAIT: begin
               if (done) begin
                  if (redir_pend) begin
                     // Stale fetch from the wrong path: drop it
                     instr_d      = NOP_INSTR;
                     valid_d      = 1'b0;
                     pc_d         = redir_pc;
                     redir_pend_d = 1'b0;
                     state_d      = S_REQ;
                  end else if (!id_stall) begin
                     instr_d = imem_rdata;
                     npc_d   = seq_npc;
                     valid_d = 1'b1;
                     pc_d    = seq_npc;
                     state_d = S_REQ;
                  end else begin
                     hold_instr_d = imem_rdata;
                     hold_npc_d   = seq_npc;
                     state_d      = S_HOLD;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_HOLD: begin
               if (!id_stall) begin
                  instr_d = hold_instr;
                  npc_d   = hold_npc;
                  valid_d = 1'b1;
                  pc_d    = hold_npc;
                  state_d = S_REQ;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Every entry into REQ latches the address to fetch
      if (state_d == S_REQ) begin
         req_addr_d = pc_d;
      end

      req_d = (state_d == S_REQ) || (state_d == S_WAIT);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         redir_pc    <= 32'h0;
         redir_pend  <= 1'b0;
         hold_instr  <= 32'h0;
         hold_npc    <= 32'h0;
         imem_req    <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_npc   <= 32'h0;
         if_id_valid <= 1'b0;
      end else begin
         pc          <= pc_d;
         req_addr    <= req_addr_d;
         redir_pc    <= redir_pc_d;
         redir_pend  <= redir_pend_d;
         hold_instr  <= hold_instr_d;
         hold_npc    <= hold_npc_d;
         imem_req    <= req_d;
         if_id_instr <= instr_d;
         if_id_npc   <= npc_d;
         if_id_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: a transaction-level reference model
// (current fetch address, outstanding redirect, held instruction) predicts the
// outputs for every cycle; directed scenarios pin the model with literal
// expectations, then randomized latency/stall/redirect/reset traffic follows.
// Define FETCH_TIMEOUT_EN to also exercise the timeout feature.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] DATA_OFS = 32'h0000_0100;
`ifdef FETCH_TIMEOUT_EN
   localparam int TMO = 16;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mem_pcsrc;
   logic [31:0] ex_mem_npc;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic        if_id_valid;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   fetch_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .ex_mem_pcsrc (ex_mem_pcsrc),
      .ex_mem_npc   (ex_mem_npc),
      .id_stall     (id_stall),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .if_id_instr  (if_id_instr),
      .if_id_npc    (if_id_npc),
      .if_id_valid  (if_id_valid)
`ifdef FETCH_TIMEOUT_EN
      ,
      .fetch_err    (fetch_err)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: expected outputs for the current cycle plus fetch context
   bit          m_known = 0;
   logic        e_req;
   logic [31:0] e_addr, e_instr, e_npc;
   logic        e_valid;
   logic        e_err;
   logic [31:0] m_pc;
   bit          m_idle, m_hold, m_pend;
   logic [31:0] h_instr, h_npc, m_pend_pc;
   int          m_wcnt;

   // Memory responder
   bit          mem_busy = 0;
   int          mem_wcnt, mem_lat;
   int unsigned lat_lo = 0, lat_hi = 0;
   bit          lat_never = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic compare();
      if (!m_known) return;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, e_addr);
      chk("if_id_valid", 32'(if_id_valid), 32'(e_valid));
      chk("if_id_instr", if_id_instr, e_instr);
      if (e_valid) chk("if_id_npc", if_id_npc, e_npc);
`ifdef FETCH_TIMEOUT_EN
      chk("fetch_err", 32'(fetch_err), 32'(e_err));
`endif
   endtask

   // Advance the model across one clock edge given this cycle's inputs
   task automatic model_step(input bit r, input bit st, input bit ps, input logic [31:0] np,
                             input bit rdy, input logic [31:0] rd);
      bit          done, tmo, start;
      logic [31:0] start_at;
      int          nw;
      if (r) begin
         m_known = 1;
         e_req = 0; e_addr = 32'h0; e_instr = NOP; e_npc = 32'h0; e_valid = 0; e_err = 0;
         m_pc = 32'h0; m_idle = 1; m_hold = 0; m_pend = 0; m_wcnt = 0;
         return;
      end
      done = e_req && rdy;
      tmo  = 0;
`ifdef FETCH_TIMEOUT_EN
      tmo = e_req && !rdy && (m_wcnt + 1 == TMO);
`endif
      nw = (e_req && !rdy && !tmo) ? m_wcnt + 1 : 0;
      start = 0;
      start_at = 32'h0;
      if (ps) begin
         e_instr = NOP; e_valid = 0;
         if (!e_req || done) begin
            m_hold = 0; m_pend = 0; m_idle = 0; start = 1; start_at = np;
         end else if (tmo) begin
            e_err = 1; e_req = 0; m_idle = 1; m_pc = np; m_pend = 0;
         end else begin
            m_pend = 1; m_pend_pc = np;
         end
      end else if (tmo) begin
         e_err = 1; e_req = 0; m_idle = 1;
         m_pc = m_pend ? m_pend_pc : e_addr;
         m_pend = 0;
         if (!st) begin e_instr = NOP; e_valid = 0; end
      end else if (done && m_pend) begin
         e_instr = NOP; e_valid = 0; m_pend = 0; start = 1; start_at = m_pend_pc;
      end else if (done && !st) begin
         e_instr = rd; e_npc = e_addr + 32'd1; e_valid = 1; start = 1; start_at = e_addr + 32'd1;
      end else if (done) begin
         m_hold = 1; h_instr = rd; h_npc = e_addr + 32'd1; e_req = 0;
      end else if (m_hold) begin
         if (!st) begin
            e_instr = h_instr; e_npc = h_npc; e_valid = 1; m_hold = 0; start = 1; start_at = h_npc;
         end
      end else begin
         if (!st) begin e_instr = NOP; e_valid = 0; end
         if (m_idle) begin m_idle = 0; start = 1; start_at = m_pc; end
      end
      if (start) begin
         m_pc = start_at; e_req = 1; e_addr = start_at;
      end
      m_wcnt = nw;
   endtask

   // One cycle: check outputs, drive inputs (memory answers per chosen latency), update model
   task automatic tick(input bit r, input bit st, input bit ps, input logic [31:0] np);
      bit          rdy;
      logic [31:0] rd;
      compare();
      if (e_req && !r) begin
         if (!mem_busy) begin
            mem_busy = 1;
            mem_wcnt = 0;
            mem_lat  = lat_never ? (1 << 30) : int'($urandom_range(lat_hi, lat_lo));
         end
         rdy = (mem_wcnt >= mem_lat);
      end else begin
         mem_busy = 0;
         rdy = ($urandom_range(3, 0) == 0);
      end
      rd = (rdy && e_req) ? e_addr + DATA_OFS : 32'hDEAD_BEEF;
      rst          = r;
      id_stall     = st;
      ex_mem_pcsrc = ps;
      ex_mem_npc   = np;
      imem_ready   = rdy;
      imem_rdata   = rd;
      if (rdy) mem_busy = 0;
      else if (mem_busy) mem_wcnt++;
      model_step(r, st, ps, np, rdy, rd);
   endtask

   task automatic do_reset();
      nxt(); tick(1, 0, 0, 32'h0);
      nxt(); tick(1, 0, 0, 32'h0);
   endtask

   initial begin
      int vcnt;
      int i;
      rst = 1; ex_mem_pcsrc = 0; ex_mem_npc = 32'h0; id_stall = 0;
      imem_ready = 0; imem_rdata = 32'h0;

      // Zero-wait memory: first delivery two edges after reset, then one per cycle
      lat_lo = 0; lat_hi = 0;
      do_reset();
      nxt();
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(if_id_valid), 32'h0);
      chk("rst_instr", if_id_instr, NOP);
      chk("rst_npc", if_id_npc, 32'h0);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("zw_first_req", 32'(imem_req), 32'h1);
      chk("zw_first_addr", imem_addr, 32'h0);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("zw_i0_valid", 32'(if_id_valid), 32'h1);
      chk("zw_i0_instr", if_id_instr, 32'h100);
      chk("zw_i0_npc", if_id_npc, 32'h1);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("zw_i1_instr", if_id_instr, 32'h101);
      chk("zw_i1_npc", if_id_npc, 32'h2);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("zw_i2_instr", if_id_instr, 32'h102);
      chk("zw_i2_npc", if_id_npc, 32'h3);
      tick(0, 0, 0, 32'h0);

      // Three-cycle latency: one valid every three cycles
      lat_lo = 2; lat_hi = 2;
      do_reset();
      vcnt = 0;
      for (int k = 0; k < 12; k++) begin
         nxt();
         if (if_id_valid) vcnt++;
         tick(0, 0, 0, 32'h0);
      end
      chk("lat3_valid_count", 32'(vcnt), 32'd3);

      // Stall for 4 cycles while the fetch of address 5 completes
      lat_lo = 0; lat_hi = 0;
      do_reset();
      for (i = 0; i < 50 && !(e_req && e_addr == 32'd5); i++) begin
         nxt(); tick(0, 0, 0, 32'h0);
      end
      chk("stall_reach_addr5", 32'(i < 50), 32'h1);
      nxt(); tick(0, 1, 0, 32'h0);
      nxt();
      chk("stall_req_low", 32'(imem_req), 32'h0);
      chk("stall_ifid_hold", if_id_instr, 32'h104);
      tick(0, 1, 0, 32'h0);
      nxt(); tick(0, 1, 0, 32'h0);
      nxt(); tick(0, 1, 0, 32'h0);
      nxt(); tick(0, 0, 0, 32'h0);
      nxt();
      chk("stall_rel_instr", if_id_instr, 32'h105);
      chk("stall_rel_npc", if_id_npc, 32'h6);
      chk("stall_rel_addr", imem_addr, 32'h6);
      tick(0, 0, 0, 32'h0);

      // Redirect during WAIT for address 8
      lat_lo = 3; lat_hi = 3;
      do_reset();
      for (i = 0; i < 200 && !(e_req && e_addr == 32'd8); i++) begin
         nxt(); tick(0, 0, 0, 32'h0);
      end
      chk("redir_reach_addr8", 32'(i < 200), 32'h1);
      nxt(); tick(0, 0, 0, 32'h0);
      nxt(); tick(0, 0, 1, 32'h40);
      nxt();
      chk("redir_flush_valid", 32'(if_id_valid), 32'h0);
      chk("redir_addr_stable", imem_addr, 32'h8);
      tick(0, 0, 0, 32'h0);
      for (i = 0; i < 20 && !(e_req && e_addr == 32'h40); i++) begin
         nxt(); tick(0, 0, 0, 32'h0);
      end
      nxt();
      chk("redir_target_addr", imem_addr, 32'h40);
      tick(0, 0, 0, 32'h0);

      // Redirect plus stall with nothing outstanding
      lat_lo = 0; lat_hi = 0;
      do_reset();
      nxt(); tick(0, 1, 1, 32'h77);
      nxt();
      chk("redir_stall_valid", 32'(if_id_valid), 32'h0);
      chk("redir_stall_addr", imem_addr, 32'h77);
      tick(0, 0, 0, 32'h0);

      // PC wrap at 2^32
      do_reset();
      nxt(); tick(0, 0, 1, 32'hFFFF_FFFF);
      nxt();
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFF);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("wrap_instr", if_id_instr, 32'h0000_00FF);
      chk("wrap_npc", if_id_npc, 32'h0);
      chk("wrap_next_addr", imem_addr, 32'h0);
      tick(0, 0, 0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
      // Memory never answers: timeout after 16 waiting cycles, then reissue
      lat_never = 1;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         nxt(); tick(0, 0, 0, 32'h0);
      end
      nxt();
      chk("tmo_before_err", 32'(fetch_err), 32'h0);
      chk("tmo_before_req", 32'(imem_req), 32'h1);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("tmo_err", 32'(fetch_err), 32'h1);
      chk("tmo_req_drop", 32'(imem_req), 32'h0);
      lat_never = 0; lat_lo = 0; lat_hi = 0;
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("tmo_reissue_addr", imem_addr, 32'h0);
      tick(0, 0, 0, 32'h0);
      nxt();
      chk("tmo_complete_instr", if_id_instr, 32'h100);
      tick(0, 0, 0, 32'h0);
`endif

      // Randomized traffic
      lat_lo = 0; lat_hi = 3;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         nxt();
         tick(($urandom_range(299, 0) == 0),
              ($urandom_range(3, 0) == 0),
              ($urandom_range(11, 0) == 0),
              $urandom);
      end
      nxt();
      compare();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch stage.
- Owns the PC register, issues requests to instruction memory over a req/ready handshake, and writes the IF/ID pipeline register.
- Handles ID-stage stalls and EX/MEM branch redirects with flush.
- Tolerates variable-latency instruction memory, so fetch no longer assumes a combinational read.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 1, PC increment per instruction (word-addressed memory).
- NOP_INSTR, 32'h0000_0000, value driven on if_id_instr for bubbles and flushes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mem_pcsrc  in  1  branch/jump taken, resolved in EX/MEM.
- ex_mem_npc  in  32  redirect target, valid when ex_mem_pcsrc=1.
- id_stall  in  1  hazard unit requests that IF/ID hold.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; stable while imem_req=1 until accepted.
- imem_ready  in  1  read data valid and transaction complete this cycle.
- imem_rdata  in  32  instruction word.
- if_id_instr  out  32  IF/ID instruction.
- if_id_npc  out  32  IF/ID next PC (fetch address + PC_INC).
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0; imem_addr=RESET_PC.
  - if_id_instr=NOP_INSTR, if_id_npc=0, if_id_valid=0.
  - redir_pend=0; hold buffer cleared.
  - Reset asserted mid-transaction abandons the transaction; a late imem_ready is ignored.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: one cycle after reset, then REQ.
  - REQ and WAIT: imem_req=1, imem_addr=req_addr. req_addr is latched from pc on entry to REQ.
  - REQ is the first request cycle; WAIT covers each following cycle until imem_ready.
- Completion is any cycle with imem_req=1 and imem_ready=1. Zero-wait memory completes in REQ.
- Completion with no redirect and no pending redirect:
  - id_stall=0: if_id_instr<=imem_rdata, if_id_npc<=req_addr+PC_INC, if_id_valid<=1, pc<=req_addr+PC_INC; next state REQ. Steady-state throughput is 1 instruction/cycle with zero-wait memory.
  - id_stall=1: capture rdata and npc in the hold buffer; IF/ID unchanged; next state HOLD, with imem_req=0.
- HOLD:
  - While id_stall=1, stay in HOLD.
  - When id_stall=0, write the buffer to IF/ID (valid=1), advance pc, go to REQ.
- No completion in a cycle:
  - id_stall=0: IF/ID gets a bubble (instr=NOP_INSTR, valid=0).
  - id_stall=1: IF/ID holds.
- Redirect (ex_mem_pcsrc=1) has highest priority and overrides id_stall.
  - IF/ID is flushed the same edge (NOP, valid=0).
  - imem_req=0, or completion in the same cycle: discard any data or hold buffer, pc<=ex_mem_npc, next state REQ.
  - imem_req=1 and imem_ready=0: imem_addr must stay stable. Latch redir_pc<=ex_mem_npc and set redir_pend=1; stay in WAIT. A later redirect before completion overwrites redir_pc.
- Completion with redir_pend=1: discard rdata, pc<=redir_pc, clear redir_pend, go to REQ. IF/ID gets a bubble.
- Arithmetic: 32-bit; pc+PC_INC wraps modulo 2^32 with no flag.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Enabled:
  - Adds parameter TIMEOUT_CYC (default 16) and output port fetch_err (1 bit, sticky, cleared only by rst).
  - A counter runs while imem_req=1 and imem_ready=0.
  - When the count reaches TIMEOUT_CYC: set fetch_err, drop imem_req for one cycle, return to REQ at the same req_addr, or at redir_pc if a redirect is pending.
- Disabled: no counter and no port; WAIT waits indefinitely.

Test Plan:
- Reset, zero-wait memory (imem_ready tied 1), rdata=addr+0x100 -> first valid IF/ID 2 cycles after rst deasserts with instr=0x100, npc=1; then one instruction per cycle: 0x101/2, 0x102/3.
- 3-cycle memory latency, no stall -> imem_addr held for 3 cycles; if_id_valid pulses once every 3 cycles; bubbles show NOP_INSTR.
- id_stall=1 for 4 cycles while a fetch of addr 5 completes -> IF/ID unchanged during the stall; the instr at 5 is delivered on the edge after stall drops; the next request goes to addr 6.
- ex_mem_pcsrc=1, npc=0x40 during WAIT for addr 8 -> IF/ID flushed immediately; imem_addr stays 8 until ready; addr-8 data discarded; next request to 0x40.
- Redirect and id_stall in the same cycle, with no request outstanding -> flush wins (valid=0); next imem_addr=target.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, imem_ready held 0 -> fetch_err=1 after 16 cycles; imem_req low 1 cycle, then re-requests the same address; a later ready completes normally.
